// File: rtl/instr_fetch.sv
`timescale 1ns/1ps
// Instruction fetch stage: program counter, ready/valid instruction-memory
// request, and the IF/ID register feeding decode. Handles hazard stalls,
// EX redirects and halting on SYSTEM opcodes (ECALL/EBREAK).
//
// state  | meaning
// -------+-----------------------------------------------------------
// BOOT   | first cycle after reset, no request, moves to RUN
// RUN    | fetching at pc whenever not stalled or redirected
// HALTED | SYSTEM opcode delivered, idle until redirect or reset
module instr_fetch #(
    parameter int               PC_W     = 8,
    parameter logic [PC_W-1:0]  RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect_en,
    input  logic [PC_W-1:0]  redirect_pc,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_valid,
    input  logic [31:0]      imem_rdata,
    output logic             ifid_valid,
    output logic [31:0]      ifid_instr,
    output logic [PC_W-1:0]  ifid_pc,
    output logic             halted
);

    localparam logic [31:0] NOP        = 32'h0000_0013;
    localparam logic [6:0]  OP_SYSTEM  = 7'b111_0011;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t          state;
    logic [PC_W-1:0] pc;
    logic            fetch_done;

    // Request only while running and neither flushing nor frozen; the
    // memory keeps no outstanding state, so dropping the request is free.
    assign imem_req   = (state == RUN) && !stall && !redirect_en;
    assign imem_addr  = pc;
    assign halted     = (state == HALTED);
    assign fetch_done = imem_req && imem_valid;

    // PC, IF/ID register and FSM; priority rst > redirect > stall > fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= BOOT;
            pc         <= RESET_PC;
            ifid_valid <= 1'b0;
            ifid_instr <= NOP;
            ifid_pc    <= '0;
        end else if (redirect_en) begin
            // Target alignment is forced; any same-cycle fetch is already
            // suppressed because imem_req is low.
            state      <= RUN;
            pc         <= {redirect_pc[PC_W-1:2], 2'b00};
            ifid_valid <= 1'b0;
            ifid_instr <= NOP;
        end else if (stall) begin
            state      <= state;
        end else if (fetch_done) begin
            ifid_valid <= 1'b1;
            ifid_instr <= imem_rdata;
            ifid_pc    <= pc;
            pc         <= pc + PC_W'(4);
            // The SYSTEM instruction itself still goes down the pipe.
            if (imem_rdata[6:0] == OP_SYSTEM) begin
                state <= HALTED;
            end
        end else begin
            // Wait state, BOOT or HALTED: bubble into IF/ID, PC holds.
            ifid_valid <= 1'b0;
            ifid_instr <= NOP;
            if (state == BOOT) begin
                state <= RUN;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
`timescale 1ns/1ps
module tb_instr_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stl;
    logic        redir;
    logic [7:0]  rpc;
    logic        vld;
    logic [31:0] rdata;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [7:0]  ifid_pc;
    logic        halted;

    logic [31:0] mem [64];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign rdata = mem[imem_addr[7:2]];

    instr_fetch #(.PC_W(8), .RESET_PC(8'h00)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stl),
        .redirect_en (redir),
        .redirect_pc (rpc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (vld),
        .imem_rdata  (rdata),
        .ifid_valid  (ifid_valid),
        .ifid_instr  (ifid_instr),
        .ifid_pc     (ifid_pc),
        .halted      (halted)
    );

    // Behavioural reference: mode 0=boot, 1=run, 2=halted; plain integer PC.
    int          m_mode;
    int          m_pc;
    bit          m_v;
    logic [31:0] m_i;
    int          m_ipc;

    always @(posedge clk or posedge rst) begin
        logic [31:0] w;
        if (rst) begin
            m_mode = 0; m_pc = 0; m_v = 0; m_i = NOP; m_ipc = 0;
        end else if (redir) begin
            m_pc = (int'(rpc) / 4) * 4;
            m_v = 0; m_i = NOP; m_mode = 1;
        end else if (stl) begin
            m_mode = m_mode;
        end else if (m_mode == 1 && vld) begin
            w = mem[m_pc / 4];
            m_i = w; m_v = 1; m_ipc = m_pc;
            m_pc = (m_pc + 4) % 256;
            if (w[6:0] == 7'h73) m_mode = 2;
        end else begin
            m_v = 0; m_i = NOP;
            if (m_mode == 0) m_mode = 1;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        bit          e_req;
        bit          e_halt;
        e_req  = (m_mode == 1) && !stl && !redir;
        e_halt = (m_mode == 2);
        checks++;
        if (imem_req !== e_req || imem_addr !== 8'(m_pc) || halted !== e_halt ||
            ifid_valid !== m_v || ifid_instr !== m_i || ifid_pc !== 8'(m_ipc)) begin
            errors++;
            $display("FAIL model t=%0t got req=%b addr=%h halt=%b v=%b instr=%h pc=%h expected req=%b addr=%h halt=%b v=%b instr=%h pc=%h",
                     $time, imem_req, imem_addr, halted, ifid_valid, ifid_instr, ifid_pc,
                     e_req, 8'(m_pc), e_halt, m_v, m_i, 8'(m_ipc));
        end
    end

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stl = 1'b0; redir = 1'b0; rpc = '0; vld = 1'b1;
        for (int i = 0; i < 64; i++) mem[i] = NOP;
        mem[0]  = 32'h0050_0093; mem[1] = 32'h00A0_0113; mem[2] = 32'h0020_81B3;
        mem[3]  = 32'h0030_8213; mem[4] = 32'h0041_8293; mem[8] = 32'h1234_5037;
        mem[16] = 32'h00C0_0393; mem[63] = 32'h0010_0313;

        repeat (2) @(posedge clk);
        @(negedge clk);
        lit("reset_valid", 32'(ifid_valid), 0);
        lit("reset_instr", ifid_instr, NOP);
        lit("reset_req", 32'(imem_req), 0);
        lit("reset_halted", 32'(halted), 0);
        next(); rst = 1'b0;                       // BOOT cycle
        @(negedge clk); lit("boot_req", 32'(imem_req), 0);
        next();                                   // after edge 1
        @(negedge clk); lit("first_req", 32'(imem_req), 1); lit("first_addr", 32'(imem_addr), 0);
        next();
        @(negedge clk); lit("w0_instr", ifid_instr, 32'h0050_0093); lit("w0_pc", 32'(ifid_pc), 0);
        next();
        @(negedge clk); lit("w1_instr", ifid_instr, 32'h00A0_0113); lit("w1_pc", 32'(ifid_pc), 4);
        next(); stl = 1'b1;
        @(negedge clk); lit("w2_instr", ifid_instr, 32'h0020_81B3); lit("stall_req", 32'(imem_req), 0);
        next(); next();
        @(negedge clk); lit("stall_hold_pc", 32'(ifid_pc), 8); lit("stall_hold_v", 32'(ifid_valid), 1);
        next(); stl = 1'b0;
        @(negedge clk); lit("resume_addr", 32'(imem_addr), 12);
        next(); redir = 1'b1; rpc = 8'h23;
        @(negedge clk); lit("pre_redir_pc", 32'(ifid_pc), 12); lit("redir_req", 32'(imem_req), 0);
        next(); redir = 1'b0;
        @(negedge clk); lit("redir_bubble", 32'(ifid_valid), 0); lit("redir_addr", 32'(imem_addr), 8'h20);
        next(); redir = 1'b1; rpc = 8'h04;
        @(negedge clk); lit("target_instr", ifid_instr, 32'h1234_5037);
        next(); redir = 1'b0; vld = 1'b0;
        next();
        @(negedge clk); lit("wait_addr", 32'(imem_addr), 4); lit("wait_bubble", ifid_instr, NOP);
        next(); vld = 1'b1;
        @(negedge clk); lit("wait_bubble2", 32'(ifid_valid), 0); lit("wait_addr2", 32'(imem_addr), 4);
        next(); redir = 1'b1; rpc = 8'hFC; mem[0] = 32'h0000_0073;
        @(negedge clk); lit("after_wait_pc", 32'(ifid_pc), 4); lit("after_wait_v", 32'(ifid_valid), 1);
        next(); redir = 1'b0;
        next();
        @(negedge clk); lit("wrap_pc", 32'(ifid_pc), 8'hFC); lit("wrap_addr", 32'(imem_addr), 0);
        next();
        @(negedge clk); lit("sys_instr", ifid_instr, 32'h0000_0073); lit("sys_valid", 32'(ifid_valid), 1);
        lit("halted_on", 32'(halted), 1); lit("halted_req", 32'(imem_req), 0);
        next(); redir = 1'b1; rpc = 8'h40;
        next(); redir = 1'b0;
        @(negedge clk); lit("unhalt", 32'(halted), 0); lit("unhalt_addr", 32'(imem_addr), 8'h40);
        next(); vld = 1'b0;
        @(negedge clk); lit("resume_instr", ifid_instr, 32'h00C0_0393);
        next();
        @(negedge clk); lit("mid_wait_addr", 32'(imem_addr), 8'h44);
        #2 rst = 1'b1;
        #1 lit("async_req", 32'(imem_req), 0); lit("async_addr", 32'(imem_addr), 0);
        lit("async_instr", ifid_instr, NOP); lit("async_valid", 32'(ifid_valid), 0);
        @(negedge clk); #2 rst = 1'b0; vld = 1'b1;
        next();
        @(negedge clk); lit("restart_req", 32'(imem_req), 1); lit("restart_addr", 32'(imem_addr), 0);

        // Randomized phase: random program with sprinkled SYSTEM opcodes.
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            if ($urandom_range(9) == 0) mem[i][6:0] = 7'h73;
        end
        for (int c = 0; c < 3000; c++) begin
            next();
            stl   = ($urandom_range(7) == 0);
            redir = ($urandom_range(11) == 0);
            rpc   = 8'($urandom);
            vld   = ($urandom_range(3) != 0);
            if ($urandom_range(199) == 0) begin
                #2 rst = 1'b1;
                @(negedge clk);
                #2 rst = 1'b0;
            end
        end
        next(); stl = 1'b0; redir = 1'b0; vld = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
